dea_feeder: RTL and testbench

Upstream sequencer for the DEA encryption core. Accepts a key and a message byte stream through a valid/ready handshake and drives the DEA pin interface (`kset`/`din`) one byte per clock. Captures the DEA's `dout` into an output FIFO and presents the encrypted stream on a valid/ready port. Issue is credit-gated, so the DEA never produces a byte that has no buffer slot.

---
 rtl/dea_feeder.sv | 152 +++++++++++++++
 tb/tb_dea_feeder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dea_feeder.sv
// dea_feeder: sequences key and message bytes into the DEA core one per clock
// and buffers its output in a first-word fall-through FIFO with credit-gated issue.
module dea_feeder #(
  parameter int KEY_LEN    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int DEA_LAT    = 1
) (
  input  logic                 dclk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          msg_len,
  input  logic [8*KEY_LEN-1:0] key_data,
  input  logic                 s_valid,
  input  logic [7:0]           s_data,
  output logic                 s_ready,
  output logic                 m_valid,
  output logic [7:0]           m_data,
  input  logic                 m_ready,
  output logic                 dea_kset,
  output logic [7:0]           dea_din,
  output logic                 dea_ce,
  input  logic [7:0]           dea_dout,
  output logic                 busy,
  output logic                 done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int IW = $clog2(DEA_LAT + 1);

  typedef enum logic [1:0] {IDLE, KEY, MSG, DRAIN} state_t;
  state_t state, next_state;

  logic [31:0]          len_q;
  logic [31:0]          issue_cnt;
  logic [8*KEY_LEN-1:0] key_q;
  logic [KW-1:0]        key_idx;
  logic [DEA_LAT-1:0]   lat_sr;
  logic [IW-1:0]        inflight;
  logic [AW:0]          fifo_count;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [7:0]           mem [FIFO_DEPTH];
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 credit_ok;
  logic                 last_key;

  // Bytes already buffered plus bytes still inside the DEA must fit the FIFO.
  assign credit_ok = (32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH);
  assign issue     = (state == MSG) && s_valid && credit_ok;
  assign last_key  = (key_idx == KW'(KEY_LEN - 1));
  assign push      = lat_sr[DEA_LAT-1];
  assign m_valid   = (fifo_count != '0);
  assign pop       = m_valid && m_ready;
  assign m_data    = m_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge dclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = KEY;
      KEY:     if (last_key) next_state = (len_q == 32'd0) ? DRAIN : MSG;
      MSG:     if (issue && (issue_cnt + 32'd1 == len_q)) next_state = DRAIN;
      DRAIN:   if (inflight == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    s_ready  = 1'b0;
    dea_ce   = 1'b0;
    dea_kset = 1'b0;
    dea_din  = 8'h00;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      KEY: begin
        dea_kset = 1'b1;
        dea_ce   = 1'b1;
        dea_din  = key_q[{key_idx, 3'b000} +: 8];
        busy     = 1'b1;
      end
      MSG: begin
        s_ready = credit_ok;
        busy    = 1'b1;
        if (issue) begin
          dea_ce  = 1'b1;
          dea_din = s_data;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        done = (inflight == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge dclk or negedge reset) begin
    if (!reset) begin
      len_q     <= '0;
      key_q     <= '0;
      key_idx   <= '0;
      issue_cnt <= '0;
    end else if (state == IDLE && start) begin
      len_q     <= msg_len;
      key_q     <= key_data;
      key_idx   <= '0;
      issue_cnt <= '0;
    end else begin
      if (state == KEY) key_idx <= key_idx + KW'(1);
      if (issue)        issue_cnt <= issue_cnt + 32'd1;
    end
  end

  // One bit per DEA pipeline stage; the oldest bit marks a dout worth capturing.
  always_ff @(posedge dclk or negedge reset) begin
    if (!reset) lat_sr <= '0;
    else        lat_sr <= (lat_sr << 1) | DEA_LAT'(issue);
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < DEA_LAT; i++) inflight = inflight + IW'(lat_sr[i]);
  end

  always_ff @(posedge dclk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge dclk) begin
    if (push) mem[wr_ptr] <= dea_dout;
  end

endmodule

// File: tb/tb_dea_feeder.sv
// Self-checking bench for dea_feeder: a DEA stub XORs message bytes with the loaded
// key, and a queue-based model predicts the encrypted stream byte for byte.
module tb_dea_feeder;
  localparam int KEY_LEN    = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int DEA_LAT    = 1;
  localparam logic [31:0] KEY = 32'hDDCCBBAA;

  logic        dclk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] msg_len = '0;
  logic [31:0] key_data = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready = 1'b0;
  logic        dea_kset;
  logic [7:0]  dea_din;
  logic        dea_ce;
  logic [7:0]  dea_dout;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = -1;
  int done_cnt = 0;
  int issued = 0;
  int popped = 0;
  int max_occ = 0;
  int bad_ce = 0;
  int din_bad = 0;
  int feed_idx = 0;
  int pulse_start_at = -1;
  bit gap_mode = 1'b0;
  bit sready_seen = 1'b0;
  bit mvalid_seen = 1'b0;
  logic [7:0] msg_q[$];
  logic [7:0] got_q[$];
  logic [7:0] key_seen[$];
  logic [7:0] kb [4];
  logic [7:0] basic_exp [8];

  dea_feeder #(.KEY_LEN(KEY_LEN), .FIFO_DEPTH(FIFO_DEPTH), .DEA_LAT(DEA_LAT)) dut (
    .dclk(dclk), .reset(reset), .start(start), .msg_len(msg_len), .key_data(key_data),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .dea_kset(dea_kset), .dea_din(dea_din), .dea_ce(dea_ce), .dea_dout(dea_dout),
    .busy(busy), .done(done)
  );

  always #5 dclk = ~dclk;

  always @(posedge dclk) cyc <= cyc + 1;

  // DEA stub: one registered stage, dout = din ^ key[i mod 4] over message index i.
  logic [7:0] stub_key [4];
  int stub_kidx;
  int stub_midx;
  logic stub_prev_kset;
  always @(posedge dclk or negedge reset) begin
    if (!reset) begin
      dea_dout <= 8'h00;
      stub_kidx <= 0;
      stub_midx <= 0;
      stub_prev_kset <= 1'b0;
    end else begin
      stub_prev_kset <= dea_kset;
      if (dea_ce && dea_kset) begin
        if (!stub_prev_kset) begin
          stub_key[0] <= dea_din;
          stub_kidx <= 1;
          stub_midx <= 0;
        end else begin
          stub_key[stub_kidx % 4] <= dea_din;
          stub_kidx <= stub_kidx + 1;
        end
      end else if (dea_ce) begin
        dea_dout <= dea_din ^ stub_key[stub_midx % 4];
        stub_midx <= stub_midx + 1;
      end
    end
  end

  always @(negedge dclk) begin
    if (reset) begin
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        popped++;
      end
      if (dea_ce && dea_kset) key_seen.push_back(dea_din);
      if (dea_ce && !dea_kset) begin
        issued++;
        if (!(s_valid && s_ready) || dea_din !== s_data) bad_ce++;
      end
      if (!dea_ce && dea_din !== 8'h00) din_bad++;
      if (issued - popped > max_occ) max_occ = issued - popped;
      if (s_ready) sready_seen = 1'b1;
      if (m_valid) mvalid_seen = 1'b1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic prep(input int len, input bit rnd);
    msg_q.delete(); got_q.delete(); key_seen.delete();
    feed_idx = 0; issued = 0; popped = 0; max_occ = 0; bad_ce = 0; din_bad = 0;
    sready_seen = 1'b0; mvalid_seen = 1'b0; done_cnt = 0; done_cyc = -1;
    for (int i = 0; i < len; i++) msg_q.push_back(rnd ? 8'($urandom) : 8'(i));
  endtask

  task automatic do_start(input int len);
    msg_len = 32'(len);
    key_data = KEY;
    start = 1'b1;
    @(posedge dclk); #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic feed(input int budget);
    int n = 0;
    bit acc;
    while (feed_idx < msg_q.size() && n < budget) begin
      s_valid = gap_mode ? (n % 2 == 0) : 1'b1;
      s_data  = s_valid ? msg_q[feed_idx] : 8'($urandom);
      start   = (n == pulse_start_at);
      @(negedge dclk);
      acc = s_valid && s_ready;
      @(posedge dclk); #1;
      if (acc) feed_idx++;
      n++;
    end
    s_valid = 1'b0;
    s_data = 8'h00;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int b = 0;
    while (done_cnt == 0 && b < budget) begin
      @(posedge dclk); #1;
      b++;
    end
    ok = (done_cnt > 0);
  endtask

  task automatic drain(input int len, input int budget);
    int b = 0;
    m_ready = 1'b1;
    while (got_q.size() < len && b < budget) begin
      @(posedge dclk); #1;
      b++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #23;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready: got %b expected 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_m_data: got %h expected 00", m_data); end
    checks++; if ({dea_kset, dea_ce} !== 2'b00) begin errors++; $display("[TB] FAIL reset_kset_ce: got %b expected 00", {dea_kset, dea_ce}); end
    checks++; if (dea_din !== 8'h00) begin errors++; $display("[TB] FAIL reset_din: got %h expected 00", dea_din); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("[TB] FAIL reset_busy_done: got %b expected 00", {busy, done}); end
    @(negedge dclk) reset = 1'b1;
    @(posedge dclk); #1;
  endtask

  task automatic test_basic();
    bit ok;
    prep(8, 1'b0);
    m_ready = 1'b1;
    gap_mode = 1'b0;
    do_start(8);
    feed(100);
    wait_done(50, ok);
    drain(8, 50);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_done_seen: got none expected 1 pulse"); end
    checks++; if (done_cyc - start_cyc != 13) begin errors++; $display("[TB] FAIL basic_done_latency: got %0d expected 13", done_cyc - start_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL basic_done_count: got %0d expected 1", done_cnt); end
    checks++; if (got_q.size() != 8) begin errors++; $display("[TB] FAIL basic_out_count: got %0d expected 8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== basic_exp[i]) begin
        errors++; $display("[TB] FAIL basic_byte%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, basic_exp[i]);
      end
    end
    checks++; if (key_seen.size() != 4) begin errors++; $display("[TB] FAIL basic_key_count: got %0d expected 4", key_seen.size()); end
    for (int i = 0; i < 4 && i < key_seen.size(); i++) begin
      checks++; if (key_seen[i] !== kb[i]) begin errors++; $display("[TB] FAIL basic_key%0d: got %h expected %h", i, key_seen[i], kb[i]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_after: got %b expected 0", busy); end
    checks++; if (din_bad != 0 || bad_ce != 0) begin errors++; $display("[TB] FAIL basic_din_idle: got %0d/%0d expected 0/0", din_bad, bad_ce); end
  endtask

  task automatic test_back_pressure();
    bit ok;
    prep(40, 1'b1);
    m_ready = 1'b0;
    gap_mode = 1'b0;
    do_start(40);
    feed(40);
    checks++; if (issued != FIFO_DEPTH) begin errors++; $display("[TB] FAIL bp_issued_stall: got %0d expected %0d", issued, FIFO_DEPTH); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_s_ready_low: got %b expected 0", s_ready); end
    checks++; if (got_q.size() != 0) begin errors++; $display("[TB] FAIL bp_no_pop: got %0d expected 0", got_q.size()); end
    m_ready = 1'b1;
    feed(200);
    wait_done(100, ok);
    drain(40, 100);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_done_seen: got none expected 1 pulse"); end
    checks++; if (max_occ > FIFO_DEPTH) begin errors++; $display("[TB] FAIL bp_overflow: got %0d expected <= %0d", max_occ, FIFO_DEPTH); end
    checks++; if (max_occ != FIFO_DEPTH) begin errors++; $display("[TB] FAIL bp_full_use: got %0d expected %0d", max_occ, FIFO_DEPTH); end
    checks++; if (got_q.size() != 40) begin errors++; $display("[TB] FAIL bp_out_count: got %0d expected 40", got_q.size()); end
    for (int i = 0; i < 40 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== (msg_q[i] ^ kb[i % 4])) begin
        errors++; $display("[TB] FAIL bp_byte%0d: got %h expected %h", i, got_q[i], msg_q[i] ^ kb[i % 4]);
      end
    end
  endtask

  task automatic test_input_gaps();
    bit ok;
    prep(8, 1'b0);
    m_ready = 1'b1;
    gap_mode = 1'b1;
    do_start(8);
    feed(100);
    gap_mode = 1'b0;
    wait_done(50, ok);
    drain(8, 50);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL gaps_done_seen: got none expected 1 pulse"); end
    checks++; if (issued != 8) begin errors++; $display("[TB] FAIL gaps_ce_pulses: got %0d expected 8", issued); end
    checks++; if (bad_ce != 0) begin errors++; $display("[TB] FAIL gaps_ce_unaccepted: got %0d expected 0", bad_ce); end
    checks++; if (din_bad != 0) begin errors++; $display("[TB] FAIL gaps_din_idle: got %0d expected 0", din_bad); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== basic_exp[i]) begin
        errors++; $display("[TB] FAIL gaps_byte%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, basic_exp[i]);
      end
    end
  endtask

  task automatic test_zero_length();
    bit ok;
    prep(0, 1'b0);
    m_ready = 1'b1;
    do_start(0);
    wait_done(20, ok);
    repeat (3) begin @(posedge dclk); #1; end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL zero_done_seen: got none expected 1 pulse"); end
    checks++; if (done_cyc - start_cyc != 4) begin errors++; $display("[TB] FAIL zero_done_latency: got %0d expected 4", done_cyc - start_cyc); end
    checks++; if (key_seen.size() != 4) begin errors++; $display("[TB] FAIL zero_key_cycles: got %0d expected 4", key_seen.size()); end
    checks++; if (sready_seen || mvalid_seen) begin errors++; $display("[TB] FAIL zero_no_stream: got s_ready=%b m_valid=%b expected 0/0", sready_seen, mvalid_seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    prep(8, 1'b0);
    m_ready = 1'b0;
    do_start(8);
    feed(7);
    checks++; if (issued != 3) begin errors++; $display("[TB] FAIL rmid_issued: got %0d expected 3", issued); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_prefill: got %b expected 1", m_valid); end
    s_valid = 1'b1;
    s_data = 8'h5A;
    reset = 1'b0;
    #1;
    checks++;
    if ({s_ready, m_valid, m_data, dea_kset, dea_ce, dea_din, busy, done} !== 21'd0) begin
      errors++; $display("[TB] FAIL rmid_outputs_zero: got %h expected 0", {s_ready, m_valid, m_data, dea_kset, dea_ce, dea_din, busy, done});
    end
    s_valid = 1'b0;
    s_data = 8'h00;
    @(posedge dclk);
    @(negedge dclk) reset = 1'b1;
    @(posedge dclk); #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_fifo_empty: got %b expected 0", m_valid); end
    prep(8, 1'b0);
    m_ready = 1'b1;
    do_start(8);
    feed(100);
    wait_done(50, ok);
    drain(8, 50);
    repeat (3) begin @(posedge dclk); #1; end
    checks++; if (done_cyc - start_cyc != 13) begin errors++; $display("[TB] FAIL rmid_done_latency: got %0d expected 13", done_cyc - start_cyc); end
    checks++; if (got_q.size() != 8) begin errors++; $display("[TB] FAIL rmid_out_count: got %0d expected 8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== basic_exp[i]) begin
        errors++; $display("[TB] FAIL rmid_byte%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, basic_exp[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int b = 0;
    prep(8, 1'b1);
    m_ready = 1'b1;
    do_start(8);
    msg_len = 32'd3;
    key_data = 32'h0;
    pulse_start_at = 6;
    feed(100);
    pulse_start_at = -1;
    while (!done && b < 40) begin
      @(posedge dclk); #1;
      b++;
    end
    start = 1'b1;
    msg_len = 32'd5;
    @(posedge dclk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b0 || dea_kset !== 1'b0) begin errors++; $display("[TB] FAIL busy_start_at_done: got busy=%b kset=%b expected 0/0", busy, dea_kset); end
    drain(8, 50);
    repeat (3) begin @(posedge dclk); #1; end
    checks++; if (done_cyc - start_cyc != 13) begin errors++; $display("[TB] FAIL busy_done_latency: got %0d expected 13", done_cyc - start_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL busy_done_count: got %0d expected 1", done_cnt); end
    checks++; if (issued != 8) begin errors++; $display("[TB] FAIL busy_issue_count: got %0d expected 8", issued); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_idle_after: got %b expected 0", busy); end
    checks++; if (got_q.size() != 8) begin errors++; $display("[TB] FAIL busy_out_count: got %0d expected 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== (msg_q[i] ^ kb[i % 4])) begin
        errors++; $display("[TB] FAIL busy_byte%0d: got %h expected %h", i, got_q[i], msg_q[i] ^ kb[i % 4]);
      end
    end
  endtask

  initial begin
    kb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    basic_exp = '{8'hAA, 8'hBA, 8'hCE, 8'hDE, 8'hAE, 8'hBE, 8'hCA, 8'hDA};
    test_reset();
    test_basic();
    test_back_pressure();
    test_input_gaps();
    test_zero_length();
    test_reset_mid_job();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
